// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding I-cache request, registered
// instruction/PC to decode, and the enable that advances the PC register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  output logic        pc_en_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  fetch_state_e state_q;
  logic [31:0]  addr_q;
  logic [31:0]  inst_q;
  logic [31:0]  inst_pc_q;
  logic         inst_valid_q;

  // Fetch FSM with the decode-side output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= 32'h0000_0000;
      inst_q       <= RESET_INSTR;
      inst_pc_q    <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
    end else if (flush_i) begin
      inst_valid_q <= 1'b0;
      // An in-flight request must still be held until the cache answers.
      case (state_q)
        REQ, DROP: state_q <= imem_valid_i ? IDLE : DROP;
        default:   state_q <= IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          addr_q  <= pc_i;
          state_q <= REQ;
        end
        REQ: begin
          if (imem_valid_i) begin
            inst_q       <= imem_rdata_i;
            inst_pc_q    <= addr_q;
            inst_valid_q <= 1'b1;
            state_q      <= FULL;
          end
        end
        FULL: begin
          if (inst_ready_i) begin
            inst_valid_q <= 1'b0;
            addr_q       <= pc_i;
            state_q      <= REQ;
          end
        end
        DROP: begin
          if (imem_valid_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req_o   = (state_q == REQ) || (state_q == DROP);
  assign imem_addr_o  = addr_q;
  assign pc_en_o      = ((state_q == REQ) && imem_valid_i) || flush_i;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit with a behavioural PC register.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        ivalid = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [31:0] target = 32'h0;
  logic [31:0] pc_q;
  logic        pc_en, req, inst_valid;
  logic [31:0] addr, inst, inst_pc;
  logic [63:0] exp_e;
  logic [63:0] sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pc_i         (pc_q),
    .pc_en_o      (pc_en),
    .flush_i      (flush),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_valid_i (ivalid),
    .imem_rdata_i (rdata),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_valid_o (inst_valid),
    .inst_ready_i (ready)
  );

  // PC register: sequential +4, or the redirect target when flushing.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= 32'h0;
    else if (pc_en) pc_q <= flush ? target : pc_q + 32'd4;
  end

  // Scoreboard: every accepted instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && inst_valid && ready && !flush) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL deliver: observed pc %h inst %h expected none", inst_pc, inst);
      end
      if (sb_q.size() != 0) begin
        exp_e = sb_q.pop_front();
        assert ({inst_pc, inst} === exp_e) else begin
          n_err++;
          $error("FAIL deliver: observed %h expected %h", {inst_pc, inst}, exp_e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_pair(input logic [31:0] a, input logic [31:0] d);
    tick();
    ivalid = 1'b1; rdata = d; flush = 1'b0; ready = 1'b1;
    #1;
    chk("hit_req", {31'b0, req}, 32'd1);
    chk("hit_addr", addr, a);
    chk("hit_pc_en", {31'b0, pc_en}, 32'd1);
    sb_q.push_back({a, d});
    tick();
    ivalid = 1'b0;
    #1;
    chk("full_valid", {31'b0, inst_valid}, 32'd1);
    chk("full_pc", inst_pc, a);
    chk("full_req", {31'b0, req}, 32'd0);
    chk("full_pc_en", {31'b0, pc_en}, 32'd0);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
    chk("rst_addr", addr, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'b0, req}, 32'd0);

    for (int i = 0; i < 4; i++) hit_pair(32'(4 * i), 32'hA000_0000 + 32'(i));

    for (int k = 0; k < 5; k++) begin
      tick();
      ivalid = 1'b0; ready = 1'b0;
      #1;
      chk("miss_req", {31'b0, req}, 32'd1);
      chk("miss_addr", addr, 32'h10);
      chk("miss_pc_en", {31'b0, pc_en}, 32'd0);
    end
    tick();
    ivalid = 1'b1; rdata = 32'h1234_5678;
    #1;
    chk("refill_pc_en", {31'b0, pc_en}, 32'd1);
    chk("refill_addr", addr, 32'h10);
    sb_q.push_back({32'h10, 32'h1234_5678});

    for (int k = 0; k < 4; k++) begin
      tick();
      ivalid = 1'b0; ready = 1'b0;
      #1;
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_inst", inst, 32'h1234_5678);
      chk("stall_pc", inst_pc, 32'h10);
      chk("stall_req", {31'b0, req}, 32'd0);
      chk("stall_pc_en", {31'b0, pc_en}, 32'd0);
    end
    tick();
    ready = 1'b1;
    #1;
    chk("stall_accept", {31'b0, inst_valid}, 32'd1);

    for (int i = 5; i < 8; i++) hit_pair(32'(4 * i), 32'hB000_0000 + 32'(i));

    for (int k = 0; k < 2; k++) begin
      tick();
      ivalid = 1'b0;
      #1;
      chk("miss20_addr", addr, 32'h20);
    end
    tick();
    flush = 1'b1; target = 32'h100;
    #1;
    chk("flush_pc_en", {31'b0, pc_en}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      flush = 1'b0;
      #1;
      chk("drop_req", {31'b0, req}, 32'd1);
      chk("drop_addr", addr, 32'h20);
      chk("drop_valid", {31'b0, inst_valid}, 32'd0);
      chk("drop_pc_en", {31'b0, pc_en}, 32'd0);
    end
    tick();
    ivalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("stale_pc_en", {31'b0, pc_en}, 32'd0);
    chk("stale_req", {31'b0, req}, 32'd1);
    tick();
    ivalid = 1'b0;
    #1;
    chk("post_drop_req", {31'b0, req}, 32'd0);
    chk("post_drop_valid", {31'b0, inst_valid}, 32'd0);

    tick();
    ivalid = 1'b1; rdata = 32'hBAD0_0001; flush = 1'b1; target = 32'h200;
    #1;
    chk("redir_addr", addr, 32'h100);
    chk("redir_req", {31'b0, req}, 32'd1);
    chk("flushv_pc_en", {31'b0, pc_en}, 32'd1);
    tick();
    ivalid = 1'b0; flush = 1'b0;
    #1;
    chk("flushv_valid", {31'b0, inst_valid}, 32'd0);
    chk("flushv_req", {31'b0, req}, 32'd0);

    tick();
    ivalid = 1'b1; rdata = 32'hC0DE_0200; ready = 1'b0;
    #1;
    chk("redir2_addr", addr, 32'h200);
    tick();
    ivalid = 1'b0; flush = 1'b1; target = 32'h300; ready = 1'b1;
    #1;
    chk("flushrdy_valid", {31'b0, inst_valid}, 32'd1);
    chk("flushrdy_pc", inst_pc, 32'h200);
    tick();
    flush = 1'b0;
    #1;
    chk("flushrdy_dropped", {31'b0, inst_valid}, 32'd0);
    chk("flushrdy_req", {31'b0, req}, 32'd0);

    hit_pair(32'h300, 32'hF00D_0300);

    tick();
    #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly downstream of the `pc` register in the RV32I direct-mapped-cache core. It samples the current PC, issues a single outstanding request to the instruction cache, and tolerates variable miss latency. It registers the returned word with its PC for the decode stage under a valid/ready handshake. It also drives the PC register's enable, so the PC advances only when a fetch completes or a redirect occurs.

## Interface
Parameters:
- `RESET_INSTR`, default 32'h0000_0013 (NOP): value of `inst_o` after reset.

Ports:
- `clk_i` in 1: clock, all state on rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `pc_i` in 32: current PC from the `pc` register.
- `pc_en_o` out 1: enable to the `pc` register (combinational).
- `flush_i` in 1: redirect from execute (taken branch/jump); the next-PC mux presents the target this cycle.
- `imem_req_o` out 1: fetch request to the I-cache.
- `imem_addr_o` out 32: fetch address; stable while `imem_req_o`=1.
- `imem_valid_i` in 1: read data valid (hit or miss refill complete).
- `imem_rdata_i` in 32: instruction word.
- `inst_o` out 32: registered instruction to decode.
- `inst_pc_o` out 32: PC of `inst_o`.
- `inst_valid_o` out 1: `inst_o`/`inst_pc_o` valid.
- `inst_ready_i` in 1: decode accepts the instruction this cycle.

## Operation
- The FSM has four states: IDLE, REQ, FULL, DROP. Internal `addr_q` drives `imem_addr_o`.
- IDLE:
  - `imem_req_o`=0.
  - Next cycle: `addr_q`<=`pc_i`, go to REQ.
- REQ:
  - `imem_req_o`=1.
  - On `imem_valid_i`: `inst_o`<=`imem_rdata_i`, `inst_pc_o`<=`addr_q`, `inst_valid_o`<=1. Go to FULL.
- FULL:
  - `imem_req_o`=0; outputs held stable.
  - On `inst_ready_i`: `inst_valid_o`<=0, `addr_q`<=`pc_i`, go to REQ.
- DROP:
  - `imem_req_o`=1 with the unchanged `addr_q`; the cache requires the request held until valid.
  - On `imem_valid_i`: discard data, go to IDLE.
- `pc_en_o` = (state==REQ & `imem_valid_i`) | `flush_i`.
- Flush handling (`flush_i` overrides all other transitions):
  - `inst_valid_o`<=0 in all states.
  - From REQ without `imem_valid_i`: go to DROP.
  - From REQ with `imem_valid_i` in the same cycle: data discarded, no capture, go to IDLE.
  - From IDLE, FULL, or DROP: go to IDLE (DROP stays DROP if `imem_valid_i` not yet seen).
- Flush together with `inst_ready_i` in FULL: flush wins; the instruction is dropped.
- Address alignment is not checked; `addr_q` is forwarded unmodified.

## Timing
- Reset values (async, immediate):
  - state IDLE, `addr_q`=0.
  - `inst_o`=`RESET_INSTR`, `inst_pc_o`=0, `inst_valid_o`=0.
  - `imem_req_o`=0, `pc_en_o`=0 (while `flush_i`=0).
- Request issue: `imem_req_o` rises 1 cycle after entering IDLE, or 1 cycle after a FULL handshake.
- Hit with same-cycle valid: `imem_valid_i` in cycle n gives `inst_valid_o`=1 in cycle n+1. Peak throughput is 1 instruction per 2 cycles.
- Miss: `imem_req_o`/`imem_addr_o` remain constant for any number of cycles until `imem_valid_i`.
- Redirect: `flush_i` in cycle n, with no outstanding request, gives target request in cycle n+2. With an outstanding miss, the target request issues 2 cycles after the stale `imem_valid_i`.
- Reset mid-miss abandons the request; the I-cache is reset on the same `rst_ni`.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_e` enum (IDLE, REQ, FULL, DROP).
  - `NOP_INSTR` constant 32'h0000_0013, used as `RESET_INSTR` default.
- No sub-module: one FSM `always_ff` plus output registers and combinational `pc_en_o`/`imem_req_o`.

## Test plan
- Reset with `rst_ni` pulsed low mid-cycle: all outputs at reset values immediately; `inst_o`=32'h13.
- pc 0x0, cache hits (valid same cycle as req), `inst_ready_i`=1: `inst_pc_o` sequence 0x0, 0x4, 0x8, one new instruction every 2 cycles. `pc_en_o` pulses coincide with `imem_valid_i`.
- Miss on 0x10 with valid after 5 cycles: `imem_addr_o`=0x10 held 5 cycles. Then `inst_o`=`imem_rdata_i`, `inst_pc_o`=0x10, and exactly one `pc_en_o` pulse.
- Decode stall, `inst_ready_i`=0 for 4 cycles in FULL: `inst_o`/`inst_pc_o` stable, `imem_req_o`=0, `pc_en_o`=0.
- Flush during a miss on 0x20, target 0x100: state DROP, data for 0x20 never appears on `inst_valid_o`. The next request is addr 0x100.
- Flush in the same cycle as `imem_valid_i`, and flush together with `inst_ready_i` in FULL: no instruction delivered. The next request uses the redirected PC.
